// File: rtl/spi_ram_arb_pkg.sv
// Shared types and constants for the two-requester SPI RAM command arbiter.
package spi_ram_arb_pkg;

    localparam int DIN_W   = 10;
    localparam int DOUT_W  = 8;
    localparam int CMD_MSB = 9;
    localparam int CMD_LSB = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LOCKED   = 2'b01,
        WAIT_RSP = 2'b10
    } arb_state_e;

    function automatic cmd_e get_cmd(input logic [DIN_W-1:0] word);
        return cmd_e'(word[CMD_MSB:CMD_LSB]);
    endfunction

endpackage

// File: rtl/spi_ram_arb_if.sv
// Requester, RAM and status signals of the arbiter; slave is the arbiter side.
interface spi_ram_arb_if;
    import spi_ram_arb_pkg::*;

    logic              r0_valid, r0_ready, r0_rsp_valid;
    logic [DIN_W-1:0]  r0_data;
    logic [DOUT_W-1:0] r0_rsp_data;
    logic              r1_valid, r1_ready, r1_rsp_valid;
    logic [DIN_W-1:0]  r1_data;
    logic [DOUT_W-1:0] r1_rsp_data;
    logic [DIN_W-1:0]  ram_din;
    logic              ram_rx_valid;
    logic [DOUT_W-1:0] ram_dout;
    logic              ram_tx_valid;
    logic              owner, busy, timeout;

    modport slave (
        input  r0_valid, r0_data, r1_valid, r1_data, ram_dout, ram_tx_valid,
        output r0_ready, r0_rsp_valid, r0_rsp_data,
        output r1_ready, r1_rsp_valid, r1_rsp_data,
        output ram_din, ram_rx_valid, owner, busy, timeout
    );

    modport master (
        output r0_valid, r0_data, r1_valid, r1_data, ram_dout, ram_tx_valid,
        input  r0_ready, r0_rsp_valid, r0_rsp_data,
        input  r1_ready, r1_rsp_valid, r1_rsp_data,
        input  ram_din, ram_rx_valid, owner, busy, timeout
    );

endinterface

// File: rtl/spi_ram_arb_timer.sv
// Clearable saturating cycle counter; o_expired flags the LIMIT-th enabled cycle.
module spi_ram_arb_timer #(
    parameter int LIMIT = 64,
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_en && (r_count >= LAST);

endmodule

// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter for the SPI RAM command port: locks address/data pairs to
// one owner, routes read data back to it and rotates priority between lock sequences.
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 64,
    parameter int RSP_TIMEOUT  = 32,
    parameter int CNT_W        = 7
) (
    input  logic         clk,
    input  logic         rst,
    spi_ram_arb_if.slave bus
);

    arb_state_e        r_state;
    logic              r_prio, r_owner, r_ram_rx_valid, r_timeout;
    logic [DIN_W-1:0]  r_ram_din;
    logic              r_rsp_valid0, r_rsp_valid1;
    logic [DOUT_W-1:0] r_rsp_data0, r_rsp_data1;

    logic              w_ready0, w_ready1, w_acc0, w_acc1, w_accept;
    logic [DIN_W-1:0]  w_beat;
    cmd_e              w_cmd;
    logic              w_in_lock, w_in_wait, w_lock_exp, w_rsp_exp;

    always_comb begin
        // NOTE: defaults first so every path assigns both readies and no latch is inferred.
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready0 = bus.r0_valid && (!bus.r1_valid || !r_prio);
                w_ready1 = bus.r1_valid && (!bus.r0_valid ||  r_prio);
            end
            LOCKED: begin
                w_ready0 = bus.r0_valid && !r_owner;
                w_ready1 = bus.r1_valid &&  r_owner;
            end
            default: ;
        endcase
    end

    assign w_acc0    = bus.r0_valid && w_ready0;
    assign w_acc1    = bus.r1_valid && w_ready1;
    assign w_accept  = w_acc0 || w_acc1;
    assign w_beat    = w_acc1 ? bus.r1_data : bus.r0_data;
    assign w_cmd     = get_cmd(w_beat);
    assign w_in_lock = (r_state == LOCKED);
    assign w_in_wait = (r_state == WAIT_RSP);

    // Lock timer restarts on every owner beat; response timer only runs while waiting.
    spi_ram_arb_timer #(.LIMIT(LOCK_TIMEOUT), .CNT_W(CNT_W)) u_lock_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_in_lock || w_accept),
        .i_en      (w_in_lock),
        .o_expired (w_lock_exp)
    );

    spi_ram_arb_timer #(.LIMIT(RSP_TIMEOUT), .CNT_W(CNT_W)) u_rsp_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_in_wait),
        .i_en      (w_in_wait),
        .o_expired (w_rsp_exp)
    );

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_prio         <= 1'b0;
            r_owner        <= 1'b0;
            r_ram_din      <= '0;
            r_ram_rx_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_rsp_valid0   <= 1'b0;
            r_rsp_valid1   <= 1'b0;
            r_rsp_data0    <= '0;
            r_rsp_data1    <= '0;
        end else begin
            r_ram_rx_valid <= w_accept;
            r_timeout      <= 1'b0;
            r_rsp_valid0   <= 1'b0;
            r_rsp_valid1   <= 1'b0;
            if (w_accept) begin
                r_ram_din <= w_beat;
                r_owner   <= w_acc1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (w_cmd)
                            WR_ADDR, RD_ADDR: r_state <= LOCKED;
                            RD_DATA:          r_state <= WAIT_RSP;
                            default:          r_state <= IDLE;
                        endcase
                    end
                end
                LOCKED: begin
                    if (w_accept) begin
                        case (w_cmd)
                            WR_DATA: begin
                                r_state <= IDLE;
                                r_prio  <= !r_owner;
                            end
                            RD_DATA: r_state <= WAIT_RSP;
                            default: r_state <= LOCKED;
                        endcase
                    end else if (w_lock_exp) begin
                        r_state   <= IDLE;
                        r_prio    <= !r_owner;
                        r_timeout <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (bus.ram_tx_valid) begin
                        if (r_owner) begin
                            r_rsp_valid1 <= 1'b1;
                            r_rsp_data1  <= bus.ram_dout;
                        end else begin
                            r_rsp_valid0 <= 1'b1;
                            r_rsp_data0  <= bus.ram_dout;
                        end
                        r_state <= IDLE;
                        r_prio  <= !r_owner;
                    end else if (w_rsp_exp) begin
                        r_state   <= IDLE;
                        r_prio    <= !r_owner;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.r0_ready     = w_ready0;
    assign bus.r1_ready     = w_ready1;
    assign bus.r0_rsp_valid = r_rsp_valid0;
    assign bus.r0_rsp_data  = r_rsp_data0;
    assign bus.r1_rsp_valid = r_rsp_valid1;
    assign bus.r1_rsp_data  = r_rsp_data1;
    assign bus.ram_din      = r_ram_din;
    assign bus.ram_rx_valid = r_ram_rx_valid;
    assign bus.owner        = r_owner;
    assign bus.busy         = (r_state != IDLE);
    assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed scenarios plus random traffic checked every cycle against a transaction-level model.
module tb_spi_ram_arbiter;

    localparam int LOCK_TIMEOUT = 64;
    localparam int RSP_TIMEOUT  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v   [2];
    logic [9:0] d   [2];
    logic       acc [2];
    logic       tx;
    logic [7:0] txd;

    int n_checks = 0;
    int n_fail   = 0;

    spi_ram_arb_if bus ();

    spi_ram_arbiter #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .RSP_TIMEOUT  (RSP_TIMEOUT),
        .CNT_W        (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.r0_valid     = v[0];
    assign bus.r0_data      = d[0];
    assign bus.r1_valid     = v[1];
    assign bus.r1_data      = d[1];
    assign bus.ram_tx_valid = tx;
    assign bus.ram_dout     = txd;

    // Model: who holds the RAM (-1 = nobody), whether a read is outstanding,
    // how long the sequence has been quiet, whose turn it is on contention.
    int         holder;
    bit         awaiting;
    int         quiet;
    bit         turn;
    bit         last;
    logic [9:0] e_din;
    bit         e_rxv, e_to;
    bit         e_rspv [2];
    logic [7:0] e_rspd [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        holder    = -1;
        awaiting  = 1'b0;
        quiet     = 0;
        turn      = 1'b0;
        last      = 1'b0;
        e_din     = '0;
        e_rxv     = 1'b0;
        e_to      = 1'b0;
        e_rspv[0] = 1'b0;
        e_rspv[1] = 1'b0;
        e_rspd[0] = '0;
        e_rspd[1] = '0;
    endfunction

    function automatic bit m_ready(input int i);
        if (awaiting)    return 1'b0;
        if (holder >= 0) return (holder == i) && v[i];
        if (!v[i])       return 1'b0;
        if (!v[1-i])     return 1'b1;
        return turn == i[0];
    endfunction

    function automatic void model_step();
        int g;
        logic [9:0] w;
        if (rst) begin
            model_reset();
            return;
        end
        e_rxv = 1'b0; e_to = 1'b0; e_rspv[0] = 1'b0; e_rspv[1] = 1'b0;
        g = m_ready(0) ? 0 : (m_ready(1) ? 1 : -1);
        if (g >= 0) begin
            w     = d[g];
            e_din = w;
            e_rxv = 1'b1;
            last  = g[0];
            case (w[9:8])
                2'b00, 2'b10: begin holder = g; quiet = 0; end
                2'b11:        begin holder = -1; awaiting = 1'b1; quiet = 0; end
                default: if (holder >= 0) begin holder = -1; turn = (g == 0); end
            endcase
        end else if (awaiting) begin
            if (tx) begin
                e_rspv[last] = 1'b1;
                e_rspd[last] = txd;
                awaiting     = 1'b0;
                turn         = !last;
            end else if (++quiet == RSP_TIMEOUT) begin
                awaiting = 1'b0;
                e_to     = 1'b1;
                turn     = !last;
            end
        end else if (holder >= 0) begin
            if (++quiet == LOCK_TIMEOUT) begin
                holder = -1;
                e_to   = 1'b1;
                turn   = !last;
            end
        end
    endfunction

    task automatic compare();
        check("r0_ready",     32'(bus.r0_ready),     32'(m_ready(0)));
        check("r1_ready",     32'(bus.r1_ready),     32'(m_ready(1)));
        check("ram_rx_valid", 32'(bus.ram_rx_valid), 32'(e_rxv));
        check("ram_din",      32'(bus.ram_din),      32'(e_din));
        check("r0_rsp_valid", 32'(bus.r0_rsp_valid), 32'(e_rspv[0]));
        check("r1_rsp_valid", 32'(bus.r1_rsp_valid), 32'(e_rspv[1]));
        check("r0_rsp_data",  32'(bus.r0_rsp_data),  32'(e_rspd[0]));
        check("r1_rsp_data",  32'(bus.r1_rsp_data),  32'(e_rspd[1]));
        check("owner",        32'(bus.owner),        32'(last));
        check("busy",         32'(bus.busy),         32'((holder >= 0) || awaiting));
        check("timeout",      32'(bus.timeout),      32'(e_to));
    endtask

    // Compare at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        acc[0] = v[0] && bus.r0_ready;
        acc[1] = v[1] && bus.r1_ready;
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        v[0] = 1'b0; v[1] = 1'b0;
        d[0] = '0;   d[1] = '0;
        tx   = 1'b0; txd  = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int         beats;
        logic       stage [2];
        quiet_inputs();
        acc[0] = 1'b0; acc[1] = 1'b0;
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",    32'(bus.busy),         32'(0));
        check("rst_rx",      32'(bus.ram_rx_valid), 32'(0));
        check("rst_owner",   32'(bus.owner),        32'(0));

        // Host lone write pair.
        do_reset();
        v[1] = 1'b1; d[1] = 10'h0A5;
        tick();
        check("t1_din_a", 32'(bus.ram_din),      32'h0A5);
        check("t1_rx_a",  32'(bus.ram_rx_valid), 32'(1));
        check("t1_busy",  32'(bus.busy),         32'(1));
        d[1] = 10'h13C;
        tick();
        v[1] = 1'b0;
        check("t1_din_d", 32'(bus.ram_din),      32'h13C);
        check("t1_idle",  32'(bus.busy),         32'(0));
        check("t1_owner", 32'(bus.owner),        32'(1));
        tick();
        check("t1_rx_end", 32'(bus.ram_rx_valid), 32'(0));

        // Contention: r0 wins after reset, holds the lock through its read.
        do_reset();
        v[0] = 1'b1; d[0] = 10'h2F0;
        v[1] = 1'b1; d[1] = 10'h011;
        tick();
        check("t2_owner", 32'(bus.owner), 32'(0));
        d[0] = 10'h300;
        #1;
        check("t2_r1_blocked", 32'(bus.r1_ready), 32'(0));
        tick();
        v[0] = 1'b0;
        tx = 1'b1; txd = 8'h5A;
        tick();
        tx = 1'b0;
        check("t2_rsp0_v", 32'(bus.r0_rsp_valid), 32'(1));
        check("t2_rsp0_d", 32'(bus.r0_rsp_data),  32'h5A);
        check("t2_rsp1_v", 32'(bus.r1_rsp_valid), 32'(0));
        #1;
        check("t2_r1_next", 32'(bus.r1_ready), 32'(1));
        tick();
        v[1] = 1'b0;
        check("t2_owner1", 32'(bus.owner), 32'(1));
        tick();

        // Round robin with both requesters streaming write pairs.
        do_reset();
        beats = 0;
        for (int i = 0; i < 2; i++) begin
            stage[i] = 1'b0;
            v[i]     = 1'b1;
            d[i]     = {2'b00, 8'($urandom)};
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    stage[i] = !stage[i];
                    d[i]     = {1'b0, stage[i], 8'($urandom)};
                end
            end
            if (bus.ram_rx_valid) begin
                check("t3_owner", 32'(bus.owner),        32'((beats / 2) % 2));
                check("t3_cmd",   32'(bus.ram_din[9:8]), 32'(beats % 2));
                beats++;
            end
        end
        check("t3_beats", 32'(beats), 32'(40));
        quiet_inputs();
        tick();

        // Lock timeout: r1 addresses then goes silent while r0 waits.
        do_reset();
        v[1] = 1'b1; d[1] = 10'h0C3;
        tick();
        v[1] = 1'b0;
        v[0] = 1'b1; d[0] = 10'h155;
        for (int i = 1; i <= LOCK_TIMEOUT; i++) begin
            tick();
            if (i == LOCK_TIMEOUT - 1) begin
                check("t4_to_early",   32'(bus.timeout), 32'(0));
                check("t4_busy_early", 32'(bus.busy),    32'(1));
            end
        end
        check("t4_timeout", 32'(bus.timeout), 32'(1));
        check("t4_idle",    32'(bus.busy),    32'(0));
        tick();
        v[0] = 1'b0;
        check("t4_r0_owner", 32'(bus.owner),   32'(0));
        check("t4_r0_din",   32'(bus.ram_din), 32'h155);
        check("t4_to_pulse", 32'(bus.timeout), 32'(0));
        tick();

        // Response timeout, then a stray ram_tx_valid in IDLE.
        do_reset();
        v[0] = 1'b1; d[0] = 10'h3AB;
        tick();
        v[0] = 1'b0;
        for (int i = 1; i <= RSP_TIMEOUT; i++) begin
            tick();
            if (i == RSP_TIMEOUT - 1) check("t5_busy_early", 32'(bus.busy), 32'(1));
        end
        check("t5_timeout", 32'(bus.timeout),      32'(1));
        check("t5_idle",    32'(bus.busy),         32'(0));
        check("t5_no_rsp",  32'(bus.r0_rsp_valid), 32'(0));
        tx = 1'b1; txd = 8'hEE;
        tick();
        tx = 1'b0;
        check("t5_spur_v0", 32'(bus.r0_rsp_valid), 32'(0));
        check("t5_spur_v1", 32'(bus.r1_rsp_valid), 32'(0));
        check("t5_spur_d0", 32'(bus.r0_rsp_data),  32'(0));
        tick();

        // Reset while r1's read is outstanding.
        do_reset();
        v[1] = 1'b1; d[1] = 10'h2AA;
        tick();
        d[1] = 10'h300;
        tick();
        v[1] = 1'b0;
        check("t6_waiting", 32'(bus.busy), 32'(1));
        rst = 1'b1; tx = 1'b1; txd = 8'h77;
        v[0] = 1'b1; d[0] = 10'h012;
        tick();
        rst = 1'b0; tx = 1'b0;
        check("t6_busy", 32'(bus.busy),         32'(0));
        check("t6_rx",   32'(bus.ram_rx_valid), 32'(0));
        check("t6_rsp0", 32'(bus.r0_rsp_valid), 32'(0));
        check("t6_rsp1", 32'(bus.r1_rsp_valid), 32'(0));
        check("t6_own",  32'(bus.owner),        32'(0));
        v[1] = 1'b1; d[1] = 10'h045;
        #1;
        check("t6_prio_r0", 32'(bus.r0_ready), 32'(1));
        check("t6_prio_r1", 32'(bus.r1_ready), 32'(0));
        tick();
        quiet_inputs();
        tick();

        // Random traffic: requesters hold each word until accepted.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && ($urandom_range(0, 99) < 40)) begin
                    v[i] = 1'b1;
                    d[i] = 10'($urandom);
                end
            end
            tx  = ($urandom_range(0, 99) < 20);
            txd = 8'($urandom);
            rst = ($urandom_range(0, 999) == 0);
            tick();
            for (int i = 0; i < 2; i++) if (acc[i]) v[i] = 1'b0;
        end
        rst = 1'b0;
        quiet_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
